// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped, write-through, no-write-allocate data cache
// for the MEM stage. Load hits answer in the same cycle. Load misses and all
// stores run one request/ready transaction with main memory while the pipeline
// is stalled, then spend one RESP cycle handing the result back.
module dcache_controller #(
  parameter int INDEX_W = 6
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [31:0] inst_MEM,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);
  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 30 - INDEX_W;

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_LB = 6'b100000;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_SB = 6'b101000;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    WRITE_WAIT = 2'd2,
    RESP       = 2'd3
  } state_t;

  state_t state_r, state_s;

  logic [LINES-1:0] valid_r;
  logic [TAG_W-1:0] tag_mem_r  [LINES];
  logic [31:0]      data_mem_r [LINES];

  logic [1:0]  lat_lane_r;
  logic        lat_byte_r;
  logic [31:0] resp_data_r;

  logic [5:0]         op_s;
  logic               is_load_s, is_store_s, is_byte_s;
  logic [INDEX_W-1:0] idx_s, lat_idx_s;
  logic [TAG_W-1:0]   tag_s, lat_tag_s;
  logic               lookup_hit_s, lat_hit_s, fill_s, wr_done_s;
  logic [31:0]        be_mask_s, merged_s;
  logic               unused_s;

  // Select the addressed byte lane and sign-extend it for LB; LW passes through.
  function automatic logic [31:0] format_load(input logic [31:0] word,
                                              input logic is_byte,
                                              input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    if (is_byte) format_load = {{24{b[7]}}, b};
    else         format_load = word;
  endfunction

  // One-hot byte enable for a single byte store.
  function automatic logic [3:0] lane_onehot(input logic [1:0] lane);
    case (lane)
      2'd0:    lane_onehot = 4'b0001;
      2'd1:    lane_onehot = 4'b0010;
      2'd2:    lane_onehot = 4'b0100;
      2'd3:    lane_onehot = 4'b1000;
      default: lane_onehot = 4'b0000;
    endcase
  endfunction

  assign op_s       = inst_MEM[31:26];
  assign is_load_s  = (op_s == OP_LW) || (op_s == OP_LB);
  assign is_store_s = (op_s == OP_SW) || (op_s == OP_SB);
  assign is_byte_s  = (op_s == OP_LB) || (op_s == OP_SB);

  assign idx_s     = addr[INDEX_W+1:2];
  assign tag_s     = addr[31:INDEX_W+2];
  // mem_addr holds the latched word address for the whole transaction.
  assign lat_idx_s = mem_addr[INDEX_W+1:2];
  assign lat_tag_s = mem_addr[31:INDEX_W+2];

  assign lookup_hit_s = valid_r[idx_s] && (tag_mem_r[idx_s] == tag_s);
  assign lat_hit_s    = valid_r[lat_idx_s] && (tag_mem_r[lat_idx_s] == lat_tag_s);
  assign fill_s       = (state_r == READ_WAIT) && mem_ready;
  assign wr_done_s    = (state_r == WRITE_WAIT) && mem_ready;

  // Store merge reuses the registered write beats: SW replaces all lanes, SB one.
  assign be_mask_s = {{8{mem_be[3]}}, {8{mem_be[2]}}, {8{mem_be[1]}}, {8{mem_be[0]}}};
  assign merged_s  = (data_mem_r[lat_idx_s] & ~be_mask_s) | (mem_wdata & be_mask_s);

  assign unused_s = ^{inst_MEM[25:0], mem_addr[1:0]};

  // Next-state decode and combinational pipeline-facing outputs.
  always_comb begin
    state_s = state_r;
    hit     = 1'b0;
    stall   = 1'b0;
    rdata   = 32'h0000_0000;
    case (state_r)
      IDLE: begin
        // While reset is asserted no access is started, so stall stays low.
        if (rst_b && is_load_s && lookup_hit_s) begin
          hit   = 1'b1;
          rdata = format_load(data_mem_r[idx_s], is_byte_s, addr[1:0]);
        end else if (rst_b && is_load_s) begin
          stall   = 1'b1;
          state_s = READ_WAIT;
        end else if (rst_b && is_store_s) begin
          stall   = 1'b1;
          state_s = WRITE_WAIT;
        end else begin
          state_s = IDLE;
        end
      end
      READ_WAIT: begin
        stall = 1'b1;
        if (mem_ready) state_s = RESP;
        else           state_s = READ_WAIT;
      end
      WRITE_WAIT: begin
        stall = 1'b1;
        if (mem_ready) state_s = RESP;
        else           state_s = WRITE_WAIT;
      end
      RESP: begin
        rdata   = resp_data_r;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register, memory-side request registers and the captured load result.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_r     <= IDLE;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_be      <= 4'b0000;
      mem_addr    <= 32'h0000_0000;
      mem_wdata   <= 32'h0000_0000;
      lat_lane_r  <= 2'd0;
      lat_byte_r  <= 1'b0;
      resp_data_r <= 32'h0000_0000;
    end else begin
      state_r <= state_s;
      if ((state_r == IDLE) && (state_s == READ_WAIT)) begin
        mem_req    <= 1'b1;
        mem_we     <= 1'b0;
        mem_be     <= 4'b1111;
        mem_addr   <= {addr[31:2], 2'b00};
        mem_wdata  <= 32'h0000_0000;
        lat_lane_r <= addr[1:0];
        lat_byte_r <= is_byte_s;
      end else if ((state_r == IDLE) && (state_s == WRITE_WAIT)) begin
        mem_req    <= 1'b1;
        mem_we     <= 1'b1;
        mem_be     <= is_byte_s ? lane_onehot(addr[1:0]) : 4'b1111;
        mem_addr   <= {addr[31:2], 2'b00};
        mem_wdata  <= is_byte_s ? {4{wdata[7:0]}} : wdata;
        lat_lane_r <= addr[1:0];
        lat_byte_r <= is_byte_s;
      end else if (fill_s || wr_done_s) begin
        mem_req <= 1'b0;
      end else begin
        mem_req <= mem_req;
      end
      if (fill_s)         resp_data_r <= format_load(mem_rdata, lat_byte_r, lat_lane_r);
      else if (wr_done_s) resp_data_r <= 32'h0000_0000;
      else                resp_data_r <= resp_data_r;
    end
  end

  // Load hit / miss counters; both wrap naturally.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      hit_cnt  <= 32'h0000_0000;
      miss_cnt <= 32'h0000_0000;
    end else begin
      if (hit) hit_cnt <= hit_cnt + 32'd1;
      else     hit_cnt <= hit_cnt;
      if ((state_r == IDLE) && (state_s == READ_WAIT)) miss_cnt <= miss_cnt + 32'd1;
      else                                             miss_cnt <= miss_cnt;
    end
  end

  // Valid bits: cleared by reset, set when a read fill completes.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      valid_r <= '0;
    end else if (fill_s) begin
      valid_r[lat_idx_s] <= 1'b1;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Tag/data arrays (not reset): fill on read completion, update on store hit.
  always_ff @(posedge clk) begin
    if (fill_s) begin
      tag_mem_r[lat_idx_s]  <= lat_tag_s;
      data_mem_r[lat_idx_s] <= mem_rdata;
    end else if (wr_done_s && lat_hit_s) begin
      data_mem_r[lat_idx_s] <= merged_s;
    end
  end
endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: directed scenarios plus randomized traffic, checked
// against a behavioural model of the cache lines and of main memory.
module tb_dcache_controller;
  localparam int INDEX_W = 6;
  localparam int LINES   = 64;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] LB  = 6'b100000;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] SB  = 6'b101000;
  localparam logic [5:0] NOP = 6'b000000;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [31:0] inst_MEM, addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] hit_cnt, miss_cnt;
  logic        hit, stall, mem_req, mem_we, mem_ready;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

  dcache_controller #(.INDEX_W(INDEX_W)) dut (
    .clk(clk), .rst_b(rst_b), .inst_MEM(inst_MEM), .addr(addr), .wdata(wdata),
    .rdata(rdata), .hit(hit), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: main memory by word address, cache as per-line records.
  logic [31:0] mem_model [logic [31:0]];
  bit          c_valid [LINES];
  logic [31:0] c_waddr [LINES];
  logic [31:0] c_data  [LINES];
  logic [31:0] m_hit_cnt, m_miss_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> 2) % LINES);
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] w);
    if (!mem_model.exists(w)) mem_model[w] = $urandom;
    return mem_model[w];
  endfunction

  function automatic logic [31:0] load_fmt(input logic [31:0] word, input logic [31:0] a, input bit is_byte);
    logic [31:0] b;
    if (!is_byte) return word;
    b = (word >> (8 * (a % 4))) & 32'hFF;
    if (b >= 32'd128) return b - 32'd256;
    return b;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] nv, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int l = 0; l < 4; l++) if (be[l]) r[8*l +: 8] = nv[8*l +: 8];
    return r;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < LINES; i++) c_valid[i] = 1'b0;
    m_hit_cnt  = 32'd0;
    m_miss_cnt = 32'd0;
  endfunction

  // One MEM-stage access: starts and ends on a falling clock edge.
  task automatic do_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                       input int dly, output logic [31:0] got_rdata, output logic got_hit);
    bit          is_load, is_store, is_byte, done;
    int          idx, stalls;
    logic [31:0] w, exp_rd, sval, exp_wdata;
    logic [3:0]  exp_be;
    is_load  = (op == LW) || (op == LB);
    is_store = (op == SW) || (op == SB);
    is_byte  = (op == LB) || (op == SB);
    idx = line_of(a);
    w   = a & 32'hFFFF_FFFC;
    check_eq("hit_cnt", hit_cnt, m_hit_cnt);
    check_eq("miss_cnt", miss_cnt, m_miss_cnt);
    inst_MEM = {op, 26'($urandom)};
    addr  = a;
    wdata = wd;
    #1;
    got_hit   = hit;
    got_rdata = rdata;
    if (!is_load && !is_store) begin
      check_eq("nop_hit", hit, 0);
      check_eq("nop_stall", stall, 0);
      check_eq("nop_rdata", rdata, 0);
      @(negedge clk);
      return;
    end
    if (is_load && c_valid[idx] && c_waddr[idx] == w) begin
      check_eq("lhit_hit", hit, 1);
      check_eq("lhit_stall", stall, 0);
      check_eq("lhit_rdata", rdata, load_fmt(c_data[idx], a, is_byte));
      m_hit_cnt++;
      @(negedge clk);
      return;
    end
    check_eq("acc_hit", hit, 0);
    check_eq("acc_stall", stall, 1);
    check_eq("acc_rdata", rdata, 0);
    if (is_load) m_miss_cnt++;
    sval      = is_byte ? ({24'd0, wd[7:0]} * 32'h0101_0101) : wd;
    exp_be    = (is_store && is_byte) ? 4'(1 << (a % 4)) : 4'hF;
    exp_wdata = sval;
    stalls = 1;
    done   = 1'b0;
    @(negedge clk);
    // Inputs are scrambled during the wait; the controller must ignore them.
    inst_MEM = $urandom;
    addr     = $urandom;
    wdata    = $urandom;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (cyc == dly) begin
        mem_ready = 1'b1;
        mem_rdata = is_load ? mem_read(w) : $urandom;
      end
      #1;
      check_eq("wait_stall", stall, 1);
      check_eq("wait_req", mem_req, 1);
      check_eq("mem_addr", mem_addr, w);
      check_eq("mem_we", mem_we, is_store);
      check_eq("mem_be", mem_be, exp_be);
      if (is_store) check_eq("mem_wdata", mem_wdata, exp_wdata);
      stalls++;
      if (cyc == dly) done = 1'b1;
      @(negedge clk);
    end
    mem_ready = 1'b0;
    mem_rdata = $urandom;
    if (!done) check_eq("wait_bound", 0, 1);
    check_eq("stall_cycles", stalls, dly + 2);
    if (is_load) begin
      c_valid[idx] = 1'b1;
      c_waddr[idx] = w;
      c_data[idx]  = mem_model[w];
      exp_rd = load_fmt(mem_model[w], a, is_byte);
    end else begin
      mem_model[w] = merge_bytes(mem_read(w), sval, exp_be);
      if (c_valid[idx] && c_waddr[idx] == w) c_data[idx] = merge_bytes(c_data[idx], sval, exp_be);
      exp_rd = 32'd0;
    end
    #1;
    check_eq("resp_stall", stall, 0);
    check_eq("resp_hit", hit, 0);
    check_eq("resp_req", mem_req, 0);
    check_eq("resp_rdata", rdata, exp_rd);
    got_rdata = rdata;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] r;
    logic        h;
    logic [5:0]  ops [5];
    ops[0] = LW; ops[1] = LB; ops[2] = SW; ops[3] = SB; ops[4] = NOP;
    rst_b = 1'b0; inst_MEM = 32'd0; addr = 32'd0; wdata = 32'd0;
    mem_ready = 1'b0; mem_rdata = 32'd0;
    model_reset();
    #3;
    check_eq("rst_req", mem_req, 0);
    check_eq("rst_we", mem_we, 0);
    check_eq("rst_be", mem_be, 0);
    check_eq("rst_addr", mem_addr, 0);
    check_eq("rst_wdata", mem_wdata, 0);
    check_eq("rst_hit_cnt", hit_cnt, 0);
    check_eq("rst_miss_cnt", miss_cnt, 0);
    check_eq("rst_stall", stall, 0);
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;

    // Fill, hit, byte store, store miss, eviction, byte loads.
    mem_model[32'h100] = 32'hDEAD_BEEF;
    do_op(LW, 32'h100, 32'd0, 3, r, h);
    check_eq("tp2_fill", r, 32'hDEAD_BEEF);
    do_op(LW, 32'h100, 32'd0, 0, r, h);
    check_eq("tp2_hit", h, 1);
    check_eq("tp2_hit_data", r, 32'hDEAD_BEEF);
    do_op(SB, 32'h102, 32'h0000_00AB, 1, r, h);
    do_op(LW, 32'h100, 32'd0, 0, r, h);
    check_eq("tp4_merge", r, 32'hDEAB_BEEF);
    do_op(SW, 32'h400, 32'h1234_5678, 0, r, h);
    do_op(LW, 32'h400, 32'd0, 2, r, h);
    check_eq("tp4_no_alloc", h, 0);
    check_eq("tp4_mem", r, 32'h1234_5678);
    do_op(LW, 32'h200, 32'd0, 0, r, h);
    do_op(LW, 32'h100, 32'd0, 1, r, h);
    check_eq("tp5_evict", h, 0);
    do_op(SW, 32'h100, 32'h80FF_1234, 0, r, h);
    do_op(LB, 32'h103, 32'd0, 0, r, h);
    check_eq("tp3_lb3", r, 32'hFFFF_FF80);
    do_op(LB, 32'h101, 32'd0, 0, r, h);
    check_eq("tp3_lb1", r, 32'h0000_0012);
    check_eq("tp3_lb1_hit", h, 1);

    // Reset in the middle of a read miss; the late ready must be ignored.
    check_eq("hit_cnt", hit_cnt, m_hit_cnt);
    check_eq("miss_cnt", miss_cnt, m_miss_cnt);
    inst_MEM = {LW, 26'd0};
    addr = 32'h300;
    @(negedge clk);
    #1;
    check_eq("pre_rst_req", mem_req, 1);
    rst_b = 1'b0;
    #1;
    check_eq("mid_rst_stall", stall, 0);
    check_eq("mid_rst_req", mem_req, 0);
    model_reset();
    @(negedge clk);
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    rst_b = 1'b1;
    inst_MEM = {NOP, 26'd0};
    @(negedge clk);
    mem_ready = 1'b0;
    do_op(LW, 32'h300, 32'd0, 0, r, h);
    check_eq("tp6_miss", h, 0);
    do_op(LW, 32'h100, 32'd0, 1, r, h);
    check_eq("tp6_invalid", h, 0);

    // Randomized traffic over a small, conflicting address set.
    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 2)
        | 32'($urandom_range(0, 3)) | (32'($urandom_range(0, 1)) << 20);
      do_op(ops[$urandom_range(0, 4)], a, $urandom, int'($urandom_range(0, 3)), r, h);
    end
    check_eq("hit_cnt", hit_cnt, m_hit_cnt);
    check_eq("miss_cnt", miss_cnt, m_miss_cnt);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
